// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single-port data RAM: the CPU has fixed priority,
// the debug/loader port is protected from starvation and can lock the RAM for itself.
module ram_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              ACLR,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  output logic [DATA_W-1:0] CPU_RDATA,
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  input  logic              DBG_LOCK,
  output logic              DBG_GNT,
  output logic              DBG_RVALID,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_WREN,
  input  logic [DATA_W-1:0] RAM_RDATA
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DBG  = 2'd2
  } rd_state_t;

  rd_state_t         rd_state;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              debt_due;

  assign debt_due = DBG_REQ && (wait_cnt == MAX_WAIT_C);

  // Grants are suppressed while ACLR is high so every output reads 0 in reset.
  always_comb begin
    // NOTE: defaults first give every path a value, so no latch is inferred.
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!ACLR) begin
      if (DBG_LOCK) begin
        dbg_gnt = DBG_REQ;
      end else if (debt_due) begin
        dbg_gnt = 1'b1;
      end else if (CPU_REQ) begin
        cpu_gnt = 1'b1;
      end else begin
        dbg_gnt = DBG_REQ;
      end
    end
  end

  assign CPU_GNT = cpu_gnt;
  assign DBG_GNT = dbg_gnt;

  // Address/data follow the winner; with no winner the last issued command is held.
  always_comb begin
    RAM_ADDR  = addr_q;
    RAM_WDATA = wdata_q;
    if (cpu_gnt) begin
      RAM_ADDR  = CPU_ADDR;
      RAM_WDATA = CPU_WDATA;
    end else if (dbg_gnt) begin
      RAM_ADDR  = DBG_ADDR;
      RAM_WDATA = DBG_WDATA;
    end
  end

  assign RAM_WREN = (cpu_gnt && CPU_WE) || (dbg_gnt && DBG_WE);

  // Read owner, starvation counter and the hold registers share one state block.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      // NOTE: the hold registers are reset so RAM_ADDR/RAM_WDATA read 0 after reset.
      rd_state <= RD_NONE;
      wait_cnt <= 8'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (cpu_gnt && !CPU_WE) begin
        rd_state <= RD_CPU;
      end else if (dbg_gnt && !DBG_WE) begin
        rd_state <= RD_DBG;
      end else begin
        rd_state <= RD_NONE;
      end

      if (!DBG_REQ || dbg_gnt) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != MAX_WAIT_C) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (cpu_gnt || dbg_gnt) begin
        addr_q  <= RAM_ADDR;
        wdata_q <= RAM_WDATA;
      end
    end
  end

  // Read data is forwarded only to the owner of the read issued last cycle.
  assign CPU_RVALID = (rd_state == RD_CPU);
  assign DBG_RVALID = (rd_state == RD_DBG);
  assign CPU_RDATA  = CPU_RVALID ? RAM_RDATA : '0;
  assign DBG_RDATA  = DBG_RVALID ? RAM_RDATA : '0;

  a_one_grant : assert property (@(posedge CLK) disable iff (ACLR)
    !(cpu_gnt && dbg_gnt));

  a_wait_bound : assert property (@(posedge CLK) disable iff (ACLR)
    wait_cnt <= MAX_WAIT_C);

  a_lock_blocks_cpu : assert property (@(posedge CLK) disable iff (ACLR)
    DBG_LOCK |-> !cpu_gnt);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a 1-cycle-latency RAM model.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              ACLR;
  logic              CPU_REQ, CPU_WE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_WDATA;
  logic              CPU_GNT, CPU_RVALID;
  logic [DATA_W-1:0] CPU_RDATA;
  logic              DBG_REQ, DBG_WE, DBG_LOCK;
  logic [ADDR_W-1:0] DBG_ADDR;
  logic [DATA_W-1:0] DBG_WDATA;
  logic              DBG_GNT, DBG_RVALID;
  logic [DATA_W-1:0] DBG_RDATA;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic              RAM_WREN;
  logic [DATA_W-1:0] RAM_RDATA = '0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_WREN) mem[RAM_ADDR] <= RAM_WDATA;
    RAM_RDATA <= mem[RAM_ADDR];
  end

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(8)) dut (
    .CLK(CLK), .ACLR(ACLR),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
    .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA),
    .DBG_LOCK(DBG_LOCK), .DBG_GNT(DBG_GNT), .DBG_RVALID(DBG_RVALID), .DBG_RDATA(DBG_RDATA),
    .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_WREN(RAM_WREN), .RAM_RDATA(RAM_RDATA)
  );

  task automatic set_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    CPU_REQ = req; CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    DBG_REQ = req; DBG_WE = we; DBG_ADDR = a; DBG_WDATA = d;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    ACLR = 1'b1; DBG_LOCK = 1'b0;
    set_cpu(1'b1, 1'b1, 10'h3AA, 32'h1111_2222);
    set_dbg(1'b0, 1'b0, '0, '0);
    repeat (2) next_cycle();
    #1;
    total++;
    if ({CPU_GNT, DBG_GNT, RAM_WREN} !== 3'b000)
      $display("FAIL rst_held_gnts got=%b want=000", {CPU_GNT, DBG_GNT, RAM_WREN});
    else passed++;
    next_cycle();
    ACLR = 1'b0;
    set_cpu(1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if ({CPU_GNT, DBG_GNT, RAM_WREN, CPU_RVALID, DBG_RVALID} !== 5'b00000)
      $display("FAIL rst_idle_ctrl got=%b want=00000",
               {CPU_GNT, DBG_GNT, RAM_WREN, CPU_RVALID, DBG_RVALID});
    else passed++;
    total++;
    if (RAM_ADDR !== 10'h000 || RAM_WDATA !== 32'h0)
      $display("FAIL rst_ram_bus got=%h/%h want=000/00000000", RAM_ADDR, RAM_WDATA);
    else passed++;
    total++;
    if (CPU_RDATA !== 32'h0 || DBG_RDATA !== 32'h0)
      $display("FAIL rst_rdata got=%h/%h want=0/0", CPU_RDATA, DBG_RDATA);
    else passed++;
  endtask

  task automatic test_cpu_write_read();
    next_cycle();
    set_cpu(1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF);
    #1;
    total++;
    if ({CPU_GNT, RAM_WREN} !== 2'b11 || RAM_ADDR !== 10'h005 || RAM_WDATA !== 32'hDEAD_BEEF)
      $display("FAIL cpu_wr_issue got=%b %h %h want=11 005 deadbeef",
               {CPU_GNT, RAM_WREN}, RAM_ADDR, RAM_WDATA);
    else passed++;
    next_cycle();
    set_cpu(1'b1, 1'b0, 10'h005, 32'h0);
    #1;
    total++;
    if ({CPU_GNT, RAM_WREN, CPU_RVALID} !== 3'b100)
      $display("FAIL cpu_rd_issue got=%b want=100", {CPU_GNT, RAM_WREN, CPU_RVALID});
    else passed++;
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 32'hDEAD_BEEF || DBG_RVALID !== 1'b0)
      $display("FAIL cpu_rd_return got=%b %h dbg=%b want=1 deadbeef dbg=0",
               CPU_RVALID, CPU_RDATA, DBG_RVALID);
    else passed++;
    total++;
    if (RAM_ADDR !== 10'h005 || CPU_GNT !== 1'b0)
      $display("FAIL idle_addr_hold got=%h gnt=%b want=005 gnt=0", RAM_ADDR, CPU_GNT);
    else passed++;
    next_cycle();
    #1;
    total++;
    if (CPU_RVALID !== 1'b0 || CPU_RDATA !== 32'h0)
      $display("FAIL cpu_rd_single got=%b %h want=0 0", CPU_RVALID, CPU_RDATA);
    else passed++;
  endtask

  task automatic test_starvation();
    next_cycle();
    set_cpu(1'b1, 1'b1, 10'h010, 32'h1234_5678);
    next_cycle();
    set_cpu(1'b1, 1'b0, 10'h020, 32'h0);
    set_dbg(1'b1, 1'b0, 10'h010, 32'h0);
    for (int c = 0; c < 8; c++) begin
      if (c != 0) next_cycle();
      #1;
      total++;
      if ({CPU_GNT, DBG_GNT} !== 2'b10)
        $display("FAIL starve_cpu_wins c=%0d got=%b want=10", c, {CPU_GNT, DBG_GNT});
      else passed++;
    end
    next_cycle();
    #1;
    total++;
    if ({CPU_GNT, DBG_GNT} !== 2'b01 || RAM_ADDR !== 10'h010 || RAM_WREN !== 1'b0)
      $display("FAIL starve_forced got=%b %h we=%b want=01 010 we=0",
               {CPU_GNT, DBG_GNT}, RAM_ADDR, RAM_WREN);
    else passed++;
    next_cycle();
    set_dbg(1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if (DBG_RVALID !== 1'b1 || DBG_RDATA !== 32'h1234_5678 || CPU_RVALID !== 1'b0)
      $display("FAIL starve_dbg_return got=%b %h cpu=%b want=1 12345678 cpu=0",
               DBG_RVALID, DBG_RDATA, CPU_RVALID);
    else passed++;
    total++;
    if (CPU_GNT !== 1'b1 || dut.wait_cnt !== 8'd0)
      $display("FAIL starve_recover got=%b cnt=%0d want=1 cnt=0", CPU_GNT, dut.wait_cnt);
    else passed++;
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      DBG_LOCK = 1'b1;
      set_cpu(1'b1, 1'b0, 10'h3FF, 32'h0);
      set_dbg(1'b1, 1'b1, 10'(i), 32'hA0 + 32'(i));
      #1;
      total++;
      if ({CPU_GNT, DBG_GNT, RAM_WREN} !== 3'b011 || RAM_ADDR !== 10'(i) ||
          RAM_WDATA !== 32'hA0 + 32'(i))
        $display("FAIL lock_dbg_wr i=%0d got=%b %h %h want=011 %h %h", i,
                 {CPU_GNT, DBG_GNT, RAM_WREN}, RAM_ADDR, RAM_WDATA, 10'(i), 32'hA0 + 32'(i));
      else passed++;
    end
    next_cycle();
    DBG_LOCK = 1'b0;
    set_dbg(1'b0, 1'b0, '0, '0);
    set_cpu(1'b1, 1'b0, 10'h002, 32'h0);
    #1;
    total++;
    if ({CPU_GNT, DBG_GNT} !== 2'b10)
      $display("FAIL unlock_cpu_gnt got=%b want=10", {CPU_GNT, DBG_GNT});
    else passed++;
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 32'hA2)
      $display("FAIL lock_wr_readback got=%b %h want=1 000000a2", CPU_RVALID, CPU_RDATA);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i < 3) set_dbg(1'b1, 1'b0, 10'(i), 32'h0);
      else set_dbg(1'b0, 1'b0, '0, '0);
      #1;
      if (i > 0) begin
        total++;
        if ({DBG_RVALID, DBG_RDATA} !== {1'b1, 32'hA0 + 32'(i - 1)})
          $display("FAIL b2b_dbg_rd i=%0d got=%b %h want=1 %h", i, DBG_RVALID, DBG_RDATA,
                   32'hA0 + 32'(i - 1));
        else passed++;
      end
    end
  endtask

  task automatic test_lock_mid_read();
    next_cycle();
    set_cpu(1'b1, 1'b0, 10'h005, 32'h0);
    #1;
    total++;
    if (CPU_GNT !== 1'b1)
      $display("FAIL lmr_cpu_gnt got=%b want=1", CPU_GNT);
    else passed++;
    next_cycle();
    DBG_LOCK = 1'b1;
    set_dbg(1'b1, 1'b0, 10'h001, 32'h0);
    #1;
    total++;
    if ({CPU_GNT, DBG_GNT} !== 2'b01)
      $display("FAIL lmr_lock_gnts got=%b want=01", {CPU_GNT, DBG_GNT});
    else passed++;
    total++;
    if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 32'hDEAD_BEEF)
      $display("FAIL lmr_cpu_return got=%b %h want=1 deadbeef", CPU_RVALID, CPU_RDATA);
    else passed++;
    next_cycle();
    set_dbg(1'b0, 1'b0, '0, '0);
    set_cpu(1'b0, 1'b0, '0, '0);
    DBG_LOCK = 1'b0;
    #1;
    total++;
    if (DBG_RVALID !== 1'b1 || DBG_RDATA !== 32'hA1 || CPU_RVALID !== 1'b0)
      $display("FAIL lmr_dbg_return got=%b %h cpu=%b want=1 000000a1 cpu=0",
               DBG_RVALID, DBG_RDATA, CPU_RVALID);
    else passed++;
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    set_cpu(1'b1, 1'b0, 10'h005, 32'h0);
    #1;
    total++;
    if (CPU_GNT !== 1'b1)
      $display("FAIL rmr_cpu_gnt got=%b want=1", CPU_GNT);
    else passed++;
    #2;
    ACLR = 1'b1;
    set_cpu(1'b0, 1'b0, '0, '0);
    next_cycle();
    ACLR = 1'b0;
    #1;
    total++;
    if (CPU_RVALID !== 1'b0 || dut.rd_state !== 2'd0)
      $display("FAIL rmr_discard got=%b state=%0d want=0 state=0", CPU_RVALID, dut.rd_state);
    else passed++;
    total++;
    if (RAM_ADDR !== 10'h000)
      $display("FAIL rmr_addr got=%h want=000", RAM_ADDR);
    else passed++;
    next_cycle();
    #1;
    total++;
    if (CPU_RVALID !== 1'b0 || DBG_RVALID !== 1'b0)
      $display("FAIL rmr_no_late got=%b/%b want=0/0", CPU_RVALID, DBG_RVALID);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_lock_mid_read();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
